// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states,
// fault cause codes, bus widths and op classification helpers.
package mem_lsu_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int RADDR_WIDTH    = 5;
    localparam int RDATA_WIDTH    = 32;
    localparam int CSR_ADDR_WIDTH = 12;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic mem_size_e op_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        return ((op_size(op) == SZ_HALF) && a[0]) ||
               ((op_size(op) == SZ_WORD) && (a != 2'b00) && (is_load(op) || is_store(op)));
    endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational data formatter: store byte-enable/lane replication and
// load lane extraction with sign or zero extension.
module mem_lsu_fmt
    import mem_lsu_pkg::*;
(
    input  logic [3:0]            st_op,
    input  logic [1:0]            st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [3:0]            st_be,
    output logic [DATA_WIDTH-1:0] st_wdata,
    input  logic [3:0]            ld_op,
    input  logic [1:0]            ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = ld_rdata[8*gi +: 8];
    end

    assign byte_sel = lane[ld_addr];
    assign half_sel = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    // Loads also get a size-shaped byte enable so the bus sees a meaningful strobe.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (op_size(st_op))
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_addr;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
        if (!is_store(st_op)) begin
            st_wdata = '0;
        end
    end

    always_comb begin
        ld_data = ld_rdata;
        case (ld_op)
            MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ld_data = {24'd0, byte_sel};
            MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ld_data = {16'd0, half_sel};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage of the RV32I pipeline: runs one req/ack bus transfer per memory op and
// stalls upstream meanwhile. Optional MEM_MISALIGN_EN rejects misaligned half/word ops.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
    input  logic                      reg_we_i,
    input  logic [RDATA_WIDTH-1:0]    reg_wdata_i,
    input  logic                      mem_we_i,
    input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
    input  logic [DATA_WIDTH-1:0]     mem_data_i,
    input  logic [3:0]                mem_op_i,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
    output logic                      bus_req_o,
    output logic                      bus_we_o,
    output logic [ADDR_WIDTH-1:0]     bus_addr_o,
    output logic [DATA_WIDTH-1:0]     bus_wdata_o,
    output logic [3:0]                bus_be_o,
    input  logic                      bus_ack_i,
    input  logic [DATA_WIDTH-1:0]     bus_rdata_i,
    output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
    output logic                      reg_we_o,
    output logic [RDATA_WIDTH-1:0]    reg_wdata_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
`ifdef MEM_MISALIGN_EN
    output logic                      misalign_o,
    output logic [3:0]                misalign_cause_o,
`endif
    output logic                      stall_o,
    output logic                      bus_err_o
);

    localparam int         TIMER_W    = 16;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    lsu_state_e               state_reg;
    logic [TIMER_W-1:0]       timer_reg;
    logic [DATA_WIDTH-1:0]    load_q_reg;
    logic [3:0]               op_reg;
    logic [1:0]               addr_lo_reg;
    logic [3:0]               st_be;
    logic [DATA_WIDTH-1:0]    st_wdata;
    logic [DATA_WIDTH-1:0]    ld_data;
    logic                     done_fault;

    // The store direction comes from the op code; mem_we_i duplicates it.
    logic unused_we;
    assign unused_we = mem_we_i;

    mem_lsu_fmt u_fmt (
        .st_op    (mem_op_i),
        .st_addr  (mem_addr_i[1:0]),
        .st_data  (mem_data_i),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_op    (op_reg),
        .ld_addr  (addr_lo_reg),
        .ld_rdata (bus_rdata_i),
        .ld_data  (ld_data)
    );

`ifdef MEM_MISALIGN_EN
    logic       misalign_reg;
    logic [3:0] misalign_cause_reg;
    assign misalign_o       = misalign_reg;
    assign misalign_cause_o = misalign_cause_reg;
    assign done_fault       = bus_err_o | misalign_reg;
`else
    assign done_fault       = bus_err_o;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_err_o   <= 1'b0;
            load_q_reg  <= '0;
            timer_reg   <= '0;
            op_reg      <= MEM_NOP;
            addr_lo_reg <= '0;
`ifdef MEM_MISALIGN_EN
            misalign_reg       <= 1'b0;
            misalign_cause_reg <= '0;
`endif
        end else begin
            bus_err_o <= 1'b0;
`ifdef MEM_MISALIGN_EN
            misalign_reg       <= 1'b0;
            misalign_cause_reg <= '0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (mem_op_i != MEM_NOP) begin
                        op_reg      <= mem_op_i;
                        addr_lo_reg <= mem_addr_i[1:0];
`ifdef MEM_MISALIGN_EN
                        if (is_misaligned(mem_op_i, mem_addr_i[1:0])) begin
                            misalign_reg       <= 1'b1;
                            misalign_cause_reg <= is_store(mem_op_i) ? CAUSE_STORE_MISALIGN
                                                                     : CAUSE_LOAD_MISALIGN;
                            state_reg          <= ST_DONE;
                        end else
`endif
                        begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= is_store(mem_op_i);
                            bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            bus_be_o    <= st_be;
                            bus_wdata_o <= st_wdata;
                            timer_reg   <= '0;
                            state_reg   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus_ack_i) begin
                        bus_req_o  <= 1'b0;
                        load_q_reg <= ld_data;
                        timer_reg  <= '0;
                        state_reg  <= ST_DONE;
                    end else if ((ACK_TIMEOUT != 0) && (timer_reg == TIMER_LAST)) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        timer_reg <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // bus_err_o doubles as the "this op was aborted" flag while in DONE.
    always_comb begin
        stall_o     = 1'b0;
        reg_we_o    = reg_we_i;
        reg_waddr_o = reg_waddr_i;
        reg_wdata_o = reg_wdata_i;
        case (state_reg)
            ST_IDLE: begin
                if (mem_op_i != MEM_NOP) begin
                    stall_o  = 1'b1;
                    reg_we_o = 1'b0;
                end
            end
            ST_BUSY: begin
                stall_o  = 1'b1;
                reg_we_o = 1'b0;
            end
            ST_DONE: begin
                if (is_load(op_reg)) begin
                    reg_wdata_o = load_q_reg;
                    reg_we_o    = reg_we_i & ~done_fault;
                end else begin
                    reg_we_o = 1'b0;
                end
            end
            default: begin
                stall_o  = 1'b0;
                reg_we_o = 1'b0;
            end
        endcase
    end

    assign csr_we_o    = csr_we_i;
    assign csr_waddr_o = csr_waddr_i;
    assign csr_wdata_o = csr_wdata_i;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a driver issues ops, a bus responder checks and acks,
// and a write-back monitor compares retirements against a behavioural model.
`timescale 1ns/1ps
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int ACK_TO = 16;
    localparam int NEVER  = 1000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic        reg_we_i, reg_we_o;
    logic [31:0] reg_wdata_i, reg_wdata_o;
    logic        mem_we_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic [3:0]  mem_op_i;
    logic        csr_we_i, csr_we_o;
    logic [11:0] csr_waddr_i, csr_waddr_o;
    logic [31:0] csr_wdata_i, csr_wdata_o;
    logic        bus_req_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
    logic        stall_o, bus_err_o;
`ifdef MEM_MISALIGN_EN
    logic        misalign_o;
    logic [3:0]  misalign_cause_o;
`endif

    always #5 clk_i = ~clk_i;

    mem_lsu #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_op_i(mem_op_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
`ifdef MEM_MISALIGN_EN
        .misalign_o(misalign_o), .misalign_cause_o(misalign_cause_o),
`endif
        .stall_o(stall_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
        logic        mis;
        logic [3:0]  cause;
        logic        csr_we;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        int          stalls;
        int          tag;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chk;
        logic [31:0] wdata;
        int          wt;
        logic [31:0] rdata;
    } bus_t;

    wb_t  sb_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   failures = 0;
    logic instr_valid = 1'b0;
    int   tag_cnt = 0;

    task automatic check32(input string name, input int tag, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s op#%0d actual=%h required=%h", name, tag, act, exp);
        end
    endtask

    // Reference load result from the rules: pick the lane by byte address, then extend.
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (op)
            MEM_LB:  return (b >= 128)   ? b + 32'hFFFFFF00 : b;
            MEM_LBU: return b;
            MEM_LH:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            MEM_LHU: return h;
            default: return rd;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic we, input logic [31:0] wd,
                         input int wt, input logic [31:0] rdata);
        wb_t  e;
        bus_t b;
        bit   ld, st, to, mis;
        int   n;
        ld  = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        st  = op inside {MEM_SB, MEM_SH, MEM_SW};
        to  = (wt >= ACK_TO);
        mis = 1'b0;
`ifdef MEM_MISALIGN_EN
        mis = ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && a[0]) ||
              ((op inside {MEM_LW, MEM_SW}) && (a % 4 != 0));
`endif
        e.tag       = tag_cnt++;
        e.waddr     = rd;
        e.mis       = mis;
        e.cause     = mis ? (st ? 4'd6 : 4'd4) : 4'd0;
        e.err       = (ld || st) && !mis && to;
        e.csr_we    = 1'($urandom);
        e.csr_waddr = 12'($urandom);
        e.csr_wdata = $urandom;
        if (!ld && !st) begin
            e.we = we; e.wdata = wd; e.stalls = 0;
        end else begin
            e.we     = ld && we && !to && !mis;
            e.wdata  = ld ? model_load(op, a, rdata) : wd;
            e.stalls = mis ? 1 : (to ? 1 + ACK_TO : 2 + wt);
            if (!mis) begin
                b.we    = st;
                b.addr  = a - (a % 4);
                b.chk   = st;
                b.wt    = wt;
                b.rdata = rdata;
                case (op)
                    MEM_SB:  begin b.be = 4'(1 << (a % 4)); b.wdata = (d & 32'hFF) * 32'h01010101; end
                    MEM_SH:  begin b.be = ((a / 2) % 2 == 1) ? 4'hC : 4'h3; b.wdata = (d & 32'hFFFF) * 32'h00010001; end
                    default: begin b.be = 4'hF; b.wdata = d; end
                endcase
                bus_q.push_back(b);
            end
        end
        sb_q.push_back(e);
        mem_op_i    = op;
        mem_addr_i  = a;
        mem_data_i  = d;
        mem_we_i    = st;
        reg_waddr_i = rd;
        reg_we_i    = we;
        reg_wdata_i = wd;
        csr_we_i    = e.csr_we;
        csr_waddr_i = e.csr_waddr;
        csr_wdata_i = e.csr_wdata;
        instr_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (stall_o && n < 200);
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL retire_timeout op#%0d actual=stalled required=retire", e.tag);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Write-back monitor: one line per retired op.
    initial begin
        wb_t e;
        int  stall_cnt;
        stall_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i || !instr_valid) begin
                stall_cnt = 0;
            end else if (stall_o) begin
                stall_cnt++;
            end else begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL retire_unexpected actual=retire required=none");
                end else begin
                    e = sb_q.pop_front();
                    $display("op#%0d retire we=%0b rd=%0d wdata=%h err=%0b stalls=%0d",
                             e.tag, reg_we_o, reg_waddr_o, reg_wdata_o, bus_err_o, stall_cnt);
                    check32("stall_cycles", e.tag, 32'(stall_cnt), 32'(e.stalls));
                    check32("reg_we", e.tag, 32'(reg_we_o), 32'(e.we));
                    check32("reg_waddr", e.tag, 32'(reg_waddr_o), 32'(e.waddr));
                    if (e.we) check32("reg_wdata", e.tag, reg_wdata_o, e.wdata);
                    check32("bus_err", e.tag, 32'(bus_err_o), 32'(e.err));
                    check32("csr_we", e.tag, 32'(csr_we_o), 32'(e.csr_we));
                    check32("csr_waddr", e.tag, 32'(csr_waddr_o), 32'(e.csr_waddr));
                    check32("csr_wdata", e.tag, csr_wdata_o, e.csr_wdata);
`ifdef MEM_MISALIGN_EN
                    check32("misalign", e.tag, 32'(misalign_o), 32'(e.mis));
                    if (e.mis) check32("misalign_cause", e.tag, 32'(misalign_cause_o), 32'(e.cause));
`endif
                end
                stall_cnt = 0;
            end
        end
    end

    // Bus responder: checks the request against the model, acks after wt cycles,
    // and throws stray acks while no request is up.
    initial begin
        bus_t cur;
        int   k;
        k = 0;
        cur.wt = NEVER; cur.rdata = '0; cur.we = 1'b0; cur.addr = '0;
        cur.be = '0; cur.chk = 1'b0; cur.wdata = '0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            bus_ack_i = 1'b0;
            if (bus_req_o && !rst_i) begin
                if (k == 0) begin
                    if (bus_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL bus_req_unexpected actual=1 required=0");
                        cur.wt = NEVER; cur.chk = 1'b0; cur.addr = bus_addr_o; cur.we = bus_we_o;
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                check32("bus_addr", k, bus_addr_o, cur.addr);
                check32("bus_we", k, 32'(bus_we_o), 32'(cur.we));
                if (cur.chk) begin
                    check32("bus_be", k, 32'(bus_be_o), 32'(cur.be));
                    check32("bus_wdata", k, bus_wdata_o, cur.wdata);
                end
                if (k == cur.wt) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = cur.rdata;
                end
                k++;
            end else begin
                k = 0;
                if ($urandom_range(0, 3) == 0) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = $urandom;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        mem_op_i = MEM_NOP; mem_addr_i = '0; mem_data_i = '0; mem_we_i = 1'b0;
        reg_waddr_i = '0; reg_we_i = 1'b0; reg_wdata_i = '0;
        csr_we_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check32("rst_bus_req", 0, 32'(bus_req_o), 32'd0);
        check32("rst_bus_we", 0, 32'(bus_we_o), 32'd0);
        check32("rst_bus_be", 0, 32'(bus_be_o), 32'd0);
        check32("rst_bus_addr", 0, bus_addr_o, 32'd0);
        check32("rst_bus_wdata", 0, bus_wdata_o, 32'd0);
        check32("rst_bus_err", 0, 32'(bus_err_o), 32'd0);
        check32("rst_stall", 0, 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Directed cases.
        issue(MEM_NOP, 32'h0,   32'h0,  5'd5, 1'b1, 32'd7,  0, 32'h0);
        issue(MEM_LW,  32'h100, 32'h0,  5'd3, 1'b1, 32'h55, 2, 32'hDEADBEEF);
        issue(MEM_LB,  32'h103, 32'h0,  5'd4, 1'b1, 32'h0,  1, 32'h80123456);
        issue(MEM_LBU, 32'h103, 32'h0,  5'd6, 1'b1, 32'h0,  0, 32'h80123456);
        issue(MEM_LHU, 32'h102, 32'h0,  5'd7, 1'b1, 32'h0,  3, 32'hBEEF1234);
        issue(MEM_LH,  32'h100, 32'h0,  5'd8, 1'b1, 32'h0,  0, 32'h00008001);
        issue(MEM_SB,  32'h101, 32'hAB, 5'd9, 1'b1, 32'h0,  1, 32'h0);
        issue(MEM_SH,  32'h102, 32'h1234CDEF, 5'd10, 1'b1, 32'h0, 0, 32'h0);
        issue(MEM_LW,  32'h104, 32'h0,  5'd11, 1'b1, 32'h0, NEVER, 32'h0);
        issue(MEM_SW,  32'h108, 32'hCAFEF00D, 5'd12, 1'b1, 32'h0, NEVER, 32'h0);
        issue(MEM_NOP, 32'h0,   32'h0,  5'd13, 1'b1, 32'h99, 0, 32'h0);

        // Reset in the middle of an outstanding load: req must fall without a clock edge.
        instr_valid = 1'b0;
        mem_op_i    = MEM_LW;
        mem_addr_i  = 32'h200;
        bus_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'hF, chk: 1'b0, wdata: 32'h0,
                          wt: NEVER, rdata: 32'h0});
        repeat (3) @(negedge clk_i);
        check32("req_before_rst", 0, 32'(bus_req_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check32("async_rst_req", 0, 32'(bus_req_o), 32'd0);
        mem_op_i = MEM_NOP;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bus_q.delete();
        repeat (2) @(negedge clk_i);
        check32("post_rst_req", 0, 32'(bus_req_o), 32'd0);
        check32("post_rst_stall", 0, 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            int         wt;
            op = 4'($urandom_range(0, 8));
            wt = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 4);
            issue(op, $urandom & 32'h0000FFFF, $urandom, 5'($urandom), 1'($urandom),
                  $urandom, wt, $urandom);
        end

        mem_op_i    = MEM_NOP;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check32("sb_drained", 0, 32'(sb_q.size()), 32'd0);
        check32("bus_drained", 0, 32'(bus_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
